// File: rtl/bsg_manycore_pkt_encode_pkg.sv
// Shared definitions for the manycore packet encoder.
//   pkt_op_e    : opcode carried in every packet
//   pkt_width_f : encoded packet width for a given parameter set
package bsg_manycore_pkt_encode_pkg;

   typedef enum logic [1:0] {
      e_op_load   = 2'b00,
      e_op_store  = 2'b01,
      e_op_config = 2'b10
   } pkt_op_e;

   function automatic int pkt_width_f(input int x_w, input int y_w,
                                      input int data_w, input int addr_w);
      return addr_w + 2 + data_w/8 + data_w + 2*(x_w + y_w);
   endfunction

endpackage

// File: rtl/bsg_manycore_pkt_fifo.sv
// Small synchronous FIFO holding encoded packets.
//   clk_i, reset_n_i  : clock, synchronous active-low reset (empties the FIFO)
//   v_i/ready_o/data_i: enqueue side; ready_o is low while full or in reset
//   v_o/ready_i/data_o: dequeue side; data_o is the head entry
// els must be a power of two so the pointers wrap by natural overflow.
module bsg_manycore_pkt_fifo
   import bsg_manycore_pkt_encode_pkg::*;
#(
   parameter int width = 76,
   parameter int els   = 2
)(
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             v_i,
   output logic             ready_o,
   input  logic [width-1:0] data_i,
   output logic             v_o,
   input  logic             ready_i,
   output logic [width-1:0] data_o
);

   localparam int ptr_w_lp = (els > 1) ? $clog2(els) : 1;
   localparam int cnt_w_lp = ptr_w_lp + 1;
   localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els);

   logic [width-1:0]    mem_q [els];
   logic [width-1:0]    mem_d [els];
   logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic                enq, deq;

   assign ready_o = reset_n_i & (count_q != els_lp);
   assign v_o     = reset_n_i & (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign enq     = v_i & ready_o;
   assign deq     = v_o & ready_i;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (enq) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_w_lp'(wr_ptr_q + 1'b1);
      end
      if (deq) begin
         rd_ptr_d = ptr_w_lp'(rd_ptr_q + 1'b1);
      end
      if (enq & ~deq) begin
         count_d = count_q + 1'b1;
      end else if (deq & ~enq) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after being written.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/bsg_manycore_pkt_encode_buffered.sv
// Encodes remote load/store requests into manycore packets and queues them
// behind a credit-limited output port.
//   clk_i, reset_n_i       : clock, synchronous active-low reset
//   v_i/ready_o            : request handshake; local requests are swallowed
//   addr_i/data_i/mask_i/we_i, my_x_i/my_y_i : request fields, source coords
//   v_o/ready_i/data_o     : packet handshake and encoded packet
//   credit_return_i        : one-cycle pulse returning one credit
//   out_credits_o, idle_o, error_o : credit count, idle, sticky overflow
module bsg_manycore_pkt_encode_buffered
   import bsg_manycore_pkt_encode_pkg::*;
#(
   parameter int x_cord_width_p    = 4,
   parameter int y_cord_width_p    = 5,
   parameter int data_width_p      = 32,
   parameter int addr_width_p      = 20,
   parameter int els_p             = 2,
   parameter int max_out_credits_p = 16
)(
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          v_i,
   output logic                          ready_o,
   input  logic [31:0]                   addr_i,
   input  logic [data_width_p-1:0]       data_i,
   input  logic [data_width_p/8-1:0]     mask_i,
   input  logic                          we_i,
   input  logic [x_cord_width_p-1:0]     my_x_i,
   input  logic [y_cord_width_p-1:0]     my_y_i,
   output logic                          v_o,
   input  logic                          ready_i,
   output logic [addr_width_p+2+data_width_p/8+data_width_p
                 +2*(x_cord_width_p+y_cord_width_p)-1:0] data_o,
   input  logic                          credit_return_i,
   output logic [7:0]                    out_credits_o,
   output logic                          idle_o,
   output logic                          error_o
);

   localparam int pw_lp = pkt_width_f(x_cord_width_p, y_cord_width_p,
                                      data_width_p, addr_width_p);
   localparam int dx_lsb_lp = addr_width_p + 2;
   localparam int dy_lsb_lp = dx_lsb_lp + x_cord_width_p;
   localparam logic [7:0] max_credits_lp = 8'(max_out_credits_p);

   logic                    remote;
   pkt_op_e                 op;
   logic [addr_width_p-1:0] pkt_addr;
   logic [pw_lp-1:0]        pkt;
   logic                    fifo_v_lo, fifo_ready_lo;
   logic                    have_credit, deq;
   logic [7:0]              credits_q, credits_d;
   logic                    error_q, error_d;
   logic [31:0]             unused_addr;

   assign unused_addr = addr_i;
   assign remote      = addr_i[31];

   always_comb begin
      op = e_op_load;
      if (we_i) begin
         op = addr_i[addr_width_p+1] ? e_op_config : e_op_store;
      end
   end

   // Word address is one bit narrower than the field; pad at the MSB.
   assign pkt_addr = {1'b0, addr_i[addr_width_p:2]};
   assign pkt = {pkt_addr, op, mask_i, data_i, my_y_i, my_x_i,
                 addr_i[dy_lsb_lp +: y_cord_width_p],
                 addr_i[dx_lsb_lp +: x_cord_width_p]};

   bsg_manycore_pkt_fifo #(
      .width (pw_lp),
      .els   (els_p)
   ) fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_i & remote),
      .ready_o   (fifo_ready_lo),
      .data_i    (pkt),
      .v_o       (fifo_v_lo),
      .ready_i   (ready_i & have_credit),
      .data_o    (data_o)
   );

   // Local requests are always taken (outside reset) and dropped.
   assign ready_o     = remote ? fifo_ready_lo : reset_n_i;
   assign have_credit = (credits_q != 8'd0);
   assign v_o         = fifo_v_lo & have_credit;
   assign deq         = v_o & ready_i;

   always_comb begin
      credits_d = credits_q;
      error_d   = error_q;
      if (deq & ~credit_return_i) begin
         credits_d = credits_q - 8'd1;
      end else if (credit_return_i & ~deq) begin
         if (credits_q == max_credits_lp) begin
            error_d = 1'b1;
         end else begin
            credits_d = credits_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         credits_q <= max_credits_lp;
         error_q   <= 1'b0;
      end else begin
         credits_q <= credits_d;
         error_q   <= error_d;
      end
   end

   assign out_credits_o = credits_q;
   assign error_o       = error_q;
   assign idle_o        = ~fifo_v_lo & (credits_q == max_credits_lp);

endmodule

// File: tb/tb_bsg_manycore_pkt_encode_buffered.sv
module tb_bsg_manycore_pkt_encode_buffered;

   localparam int PW   = 76;
   localparam int DEP  = 2;
   localparam int MAXC = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          v_i = 1'b0;
   logic [31:0]   addr_i = '0;
   logic [31:0]   data_i = '0;
   logic [3:0]    mask_i = '0;
   logic          we_i = 1'b0;
   logic [3:0]    my_x = '0;
   logic [4:0]    my_y = '0;
   logic          ready_i = 1'b0;
   logic          credit_return = 1'b0;
   logic          ready_o, v_o, idle_o, error_o;
   logic [PW-1:0] data_o;
   logic [7:0]    out_credits;

   int checks = 0;
   int errors = 0;

   // reference model: packet queue, credit count, sticky error
   logic [PW-1:0] mq[$];
   int            mcred = MAXC;
   bit            merr = 0;

   always #5 clk = ~clk;

   bsg_manycore_pkt_encode_buffered dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready_o),
      .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i), .we_i(we_i),
      .my_x_i(my_x), .my_y_i(my_y), .v_o(v_o), .ready_i(ready_i),
      .data_o(data_o), .credit_return_i(credit_return),
      .out_credits_o(out_credits), .idle_o(idle_o), .error_o(error_o)
   );

   // Packet built field by field from the request description.
   function automatic logic [PW-1:0] pkt_f(input logic [31:0] a, input logic [31:0] d,
                                           input logic [3:0] m, input logic we,
                                           input logic [3:0] mx, input logic [4:0] my);
      logic [3:0]  dx;
      logic [4:0]  dy;
      logic [1:0]  op;
      logic [19:0] wa;
      dx = 4'((a >> 22) % 16);
      dy = 5'((a >> 26) % 32);
      wa = 20'((a >> 2) % (1 << 19));
      if (!we) op = 2'd0;
      else if (((a >> 21) % 2) == 1) op = 2'd2;
      else op = 2'd1;
      return {wa, op, m, d, my, mx, dy, dx};
   endfunction

   // Advance one clock with the currently driven inputs, updating the model.
   task automatic cycle();
      bit            remote, exp_ready, exp_v, acc, deq;
      logic [PW-1:0] p;
      remote    = addr_i[31];
      exp_ready = remote ? (mq.size() < DEP) : 1'b1;
      exp_v     = (mq.size() > 0) && (mcred > 0);
      acc       = v_i && exp_ready && remote;
      deq       = exp_v && ready_i;
      p         = pkt_f(addr_i, data_i, mask_i, we_i, my_x, my_y);
      @(posedge clk);
      if (deq) void'(mq.pop_front());
      if (acc) mq.push_back(p);
      if (deq && !credit_return) mcred--;
      else if (credit_return && !deq) begin
         if (mcred == MAXC) merr = 1;
         else mcred++;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      v_i = 0; ready_i = 0; credit_return = 0; addr_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 0;
      @(posedge clk); @(negedge clk);
      reset_n = 1;
      mq.delete(); mcred = MAXC; merr = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 0;
      addr_i = 32'h8000_0000; v_i = 1;
      @(posedge clk); @(negedge clk);
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got %b exp 0", v_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_o got %b exp 0", ready_o); end
      checks++; if (out_credits !== 8'd16) begin errors++; $display("FAIL reset_credits got %0d exp 16", out_credits); end
      reset_n = 1;
      mq.delete(); mcred = MAXC; merr = 0;
      #1;
      checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL post_reset_idle got %b exp 1", idle_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", ready_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL post_reset_error got %b exp 0", error_o); end
      v_i = 0;
   endtask

   task automatic test_store();
      logic [PW-1:0] exp;
      exp = {20'h10, 2'b01, 4'hF, 32'hDEAD_BEEF, 5'd1, 4'd2, 5'd5, 4'd3};
      addr_i = 32'h94C0_0040; we_i = 1; data_i = 32'hDEAD_BEEF; mask_i = 4'hF;
      my_x = 4'd2; my_y = 5'd1; v_i = 1; ready_i = 0;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL store_ready got %b exp 1", ready_o); end
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL store_no_bypass got %b exp 0", v_o); end
      cycle();
      v_i = 0;
      #1;
      checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL store_v_o got %b exp 1", v_o); end
      checks++; if (data_o !== exp) begin errors++; $display("FAIL store_pkt got %h exp %h", data_o, exp); end
      ready_i = 1;
      cycle();
      ready_i = 0;
      checks++; if (out_credits !== 8'd15) begin errors++; $display("FAIL store_credit_dec got %0d exp 15", out_credits); end
      credit_return = 1;
      cycle();
      credit_return = 0;
   endtask

   task automatic test_load_local();
      addr_i = 32'h94C0_0040; we_i = 0; v_i = 1; ready_i = 0;
      cycle();
      v_i = 0;
      #1;
      checks++; if (data_o[55:54] !== 2'b00) begin errors++; $display("FAIL load_op got %b exp 00", data_o[55:54]); end
      checks++; if (data_o !== mq[0]) begin errors++; $display("FAIL load_pkt got %h exp %h", data_o, mq[0]); end
      ready_i = 1; cycle(); ready_i = 0;
      credit_return = 1; cycle(); credit_return = 0;
      addr_i = 32'h0000_0040; we_i = 1; v_i = 1;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL local_ready got %b exp 1", ready_o); end
      cycle();
      v_i = 0; ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL local_no_pkt got %b exp 0", v_o); end
         cycle();
      end
      ready_i = 0;
      checks++; if (out_credits !== 8'd16) begin errors++; $display("FAIL local_credits got %0d exp 16", out_credits); end
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] sent[3];
      int            got, budget;
      ready_i = 0; we_i = 1; mask_i = 4'h3;
      for (int k = 0; k < 3; k++) begin
         addr_i = 32'h8000_0000 | $urandom();
         data_i = $urandom();
         sent[k] = pkt_f(addr_i, data_i, mask_i, we_i, my_x, my_y);
         v_i = 1;
         #1;
         checks++;
         if (ready_o !== (k < 2 ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL bp_ready_%0d got %b exp %b", k, ready_o, (k < 2));
         end
         if (k < 2) cycle();
      end
      ready_i = 1;
      #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_indep got %b exp 0", ready_o); end
      got = 0; budget = 0;
      while (got < 3 && budget < 12) begin
         #1;
         if (v_o === 1'b1) begin
            checks++;
            if (data_o !== sent[got]) begin errors++; $display("FAIL bp_order_%0d got %h exp %h", got, data_o, sent[got]); end
            got++;
         end
         if (v_i && ready_o) begin cycle(); v_i = 0; end
         else cycle();
         budget++;
      end
      checks++; if (got != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got); end
      ready_i = 0; v_i = 0;
      credit_return = 1;
      for (int i = 0; i < 3; i++) cycle();
      credit_return = 0;
   endtask

   task automatic test_credits();
      v_i = 1; ready_i = 1; credit_return = 0; we_i = 1;
      for (int i = 0; i < 20; i++) begin
         addr_i = 32'h8000_0000 | $urandom(); data_i = $urandom();
         cycle();
      end
      #1;
      checks++; if (out_credits !== 8'd0) begin errors++; $display("FAIL cred_exhaust got %0d exp 0", out_credits); end
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL cred_v_blocked got %b exp 0", v_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL cred_fifo_full got %b exp 0", ready_o); end
      v_i = 0; ready_i = 0; credit_return = 1;
      cycle();
      credit_return = 0;
      #1;
      checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL cred_return_v got %b exp 1", v_o); end
      checks++; if (data_o !== mq[0]) begin errors++; $display("FAIL cred_head got %h exp %h", data_o, mq[0]); end
      ready_i = 1; credit_return = 1;
      cycle();
      ready_i = 0;
      checks++; if (out_credits !== 8'd1) begin errors++; $display("FAIL cred_coincident got %0d exp 1", out_credits); end
      checks++; if (mq.size() != 1) begin errors++; $display("FAIL cred_model_occ got %0d exp 1", mq.size()); end
      for (int i = 0; i < 15; i++) cycle();
      checks++; if (out_credits !== 8'd16 || error_o !== 1'b0) begin errors++; $display("FAIL cred_refill got %0d/%b exp 16/0", out_credits, error_o); end
      cycle();
      credit_return = 0;
      #1;
      checks++; if (error_o !== 1'b1 || out_credits !== 8'd16) begin errors++; $display("FAIL cred_overflow got %b/%0d exp 1/16", error_o, out_credits); end
      cycle(); cycle();
      checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL cred_sticky got %b exp 1", error_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready_i = 0; v_i = 1; we_i = 1;
      for (int i = 0; i < 2; i++) begin
         addr_i = 32'h8000_0000 | $urandom(); data_i = $urandom();
         cycle();
      end
      v_i = 0; ready_i = 1;
      reset_n = 0;
      #1;
      checks++; if (v_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL rmid_in_reset got v=%b r=%b exp 0/0", v_o, ready_o); end
      @(posedge clk); @(negedge clk);
      reset_n = 1;
      mq.delete(); mcred = MAXC; merr = 0;
      #1;
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rmid_v_o got %b exp 0", v_o); end
      checks++; if (out_credits !== 8'd16) begin errors++; $display("FAIL rmid_credits got %0d exp 16", out_credits); end
      checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL rmid_idle got %b exp 1", idle_o); end
      cycle();
      #1;
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rmid_no_partial got %b exp 0", v_o); end
      ready_i = 0;
   endtask

   task automatic test_random();
      bit exp_ready, exp_v, exp_idle;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         v_i     = ($urandom_range(0, 3) != 0);
         addr_i  = $urandom();
         addr_i[31] = ($urandom_range(0, 3) != 0);
         data_i  = $urandom();
         mask_i  = 4'($urandom());
         we_i    = 1'($urandom());
         my_x    = 4'($urandom());
         my_y    = 5'($urandom());
         ready_i = ($urandom_range(0, 2) != 0);
         credit_return = (mcred < MAXC) && ($urandom_range(0, 2) == 0);
         #1;
         exp_ready = addr_i[31] ? (mq.size() < DEP) : 1'b1;
         exp_v     = (mq.size() > 0) && (mcred > 0);
         exp_idle  = (mq.size() == 0) && (mcred == MAXC);
         checks++; if (ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready @%0d got %b exp %b", i, ready_o, exp_ready); end
         checks++; if (v_o !== exp_v) begin errors++; $display("FAIL rnd_v_o @%0d got %b exp %b", i, v_o, exp_v); end
         checks++; if (out_credits !== 8'(mcred)) begin errors++; $display("FAIL rnd_credits @%0d got %0d exp %0d", i, out_credits, mcred); end
         checks++; if (idle_o !== exp_idle) begin errors++; $display("FAIL rnd_idle @%0d got %b exp %b", i, idle_o, exp_idle); end
         checks++; if (error_o !== merr) begin errors++; $display("FAIL rnd_error @%0d got %b exp %b", i, error_o, merr); end
         if (exp_v) begin
            checks++; if (data_o !== mq[0]) begin errors++; $display("FAIL rnd_data @%0d got %h exp %h", i, data_o, mq[0]); end
         end
         cycle();
      end
      idle_inputs();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_store();
      test_load_local();
      test_backpressure();
      test_credits();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_pkt_encode_buffered.md
BSG_MANYCORE_PKT_ENCODE_BUFFERED -- requirements
Module: bsg_manycore_pkt_encode_buffered

Interface
REQ-001 Parameter x_cord_width_p, default 4: X coordinate width.
REQ-002 Parameter y_cord_width_p, default 5: Y coordinate width.
REQ-003 Parameter data_width_p, default 32: data width, a multiple of 8; mask width is data_width_p/8.
REQ-004 Parameter addr_width_p, default 20: packet word-address field width; addr_width_p+2+x_cord_width_p+y_cord_width_p SHALL be at most 31.
REQ-005 Parameter els_p, default 2: output FIFO depth, a power of two from 2 to 16.
REQ-006 Parameter max_out_credits_p, default 16: initial and maximum outstanding-packet credits, from 1 to 255.
REQ-007 clk_i, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-008 reset_n_i, input, 1: synchronous, active-low reset.
REQ-009 v_i, input, 1: request valid.
REQ-010 ready_o, output, 1: request accepted when v_i and ready_o are both high.
REQ-011 addr_i, input, 32: byte address; bit 31 marks a remote request; the destination X, destination Y and config fields sit above bit addr_width_p.
REQ-012 data_i, input, data_width_p: store data.
REQ-013 mask_i, input, data_width_p/8: byte mask.
REQ-014 we_i, input, 1: 1 selects store, 0 selects load.
REQ-015 my_x_i, input, x_cord_width_p; my_y_i, input, y_cord_width_p: source coordinates.
REQ-016 v_o, output, 1: packet valid.
REQ-017 ready_i, input, 1: downstream accepts the packet when v_o and ready_i are both high.
REQ-018 data_o, output, PW = addr_width_p+2+data_width_p/8+data_width_p+2*(x_cord_width_p+y_cord_width_p): the encoded packet.
REQ-019 credit_return_i, input, 1: one-cycle pulse that returns one credit.
REQ-020 out_credits_o, output, 8: current credit count.
REQ-021 idle_o, output, 1: high when the FIFO is empty and out_credits_o equals max_out_credits_p.
REQ-022 error_o, output, 1: sticky credit-overflow flag.

Function
REQ-023 Packet layout, LSB first: dest_x = addr_i[addr_width_p+2 +: xw]; dest_y = addr_i[addr_width_p+2+xw +: yw]; src_x = my_x_i; src_y = my_y_i; data_i; mask_i; op; addr field = addr_i[addr_width_p:2] zero-extended to addr_width_p bits at the MSB. Here xw and yw are the X and Y coordinate widths.
REQ-024 op SHALL be 2'b00 for a load; for a store, op = {cfg, ~cfg}, where cfg = addr_i[addr_width_p+1].
REQ-025 A remote request (addr_i[31] = 1) accepted with v_i and ready_o high SHALL be encoded and pushed into the FIFO in the same cycle.
REQ-026 A local request (addr_i[31] = 0) SHALL be accepted (ready_o = 1) and discarded; it produces no packet and consumes no credit.
REQ-027 For a remote request, ready_o = ~fifo_full; ready_o SHALL NOT depend on ready_i, and there SHALL be no same-cycle enqueue-while-full.
REQ-028 Latency: a packet SHALL become visible on v_o/data_o no earlier than the cycle after its acceptance; there is no combinational bypass.
REQ-029 v_o = ~fifo_empty & (out_credits_o != 0).
REQ-030 data_o SHALL present the FIFO head and stay stable while v_o is high and ready_i is low.
REQ-031 Packets SHALL leave in acceptance order.
REQ-032 A dequeue (v_o and ready_i high) SHALL decrement the credit count; a credit_return_i pulse SHALL increment it; both in the same cycle SHALL leave it unchanged.
REQ-033 credit_return_i with no dequeue while credits equal max_out_credits_p SHALL leave credits saturated and set error_o, which holds until reset.
REQ-034 Simultaneous enqueue and dequeue on a non-empty, non-full FIFO SHALL keep the occupancy unchanged.
REQ-035 Read and write pointers SHALL wrap modulo els_p.

Reset
REQ-036 While reset_n_i is low at a clock edge: FIFO emptied, out_credits_o = max_out_credits_p, error_o = 0, v_o = 0, ready_o = 0.
REQ-037 After reset is released: idle_o = 1, and ready_o = 1 from the first cycle.
REQ-038 Reset asserted mid-transfer SHALL drop all queued packets; no partial packet SHALL be emitted.

Structure
REQ-039 Package bsg_manycore_pkt_encode_pkg SHALL hold the op encodings (load 2'b00, store 2'b01, config 2'b10) and a function computing PW from the parameters.
REQ-040 The FIFO SHALL be the sub-module bsg_manycore_pkt_fifo (parameters width and els; valid/ready on both sides; synchronous active-low reset).
REQ-041 Encode logic SHALL be combinational in the top level, with no other state.

Verification (defaults unless stated)
REQ-042 Store: addr_i = 32'h94C0_0040, we_i = 1, data_i = 32'hDEAD_BEEF, mask_i = 4'hF, my_x_i = 2, my_y_i = 1 -> one cycle later v_o = 1 with dest_x = 3, dest_y = 5, op = 2'b01, addr field = 20'h10, src x/y = 2/1.
REQ-043 Same request with we_i = 0 -> op = 2'b00; addr_i = 32'h0000_0040 -> ready_o = 1 and no packet ever appears.
REQ-044 ready_i held low, three remote requests (els_p = 2) -> ready_o low after the second; when ready_i rises, packets exit in order.
REQ-045 max_out_credits_p = 2, no credit returns, four packets -> exactly two dequeue and then v_o stays 0; one credit_return_i pulse -> the third packet dequeues.
REQ-046 credit_return_i coincident with a dequeue -> count unchanged; credit_return_i at full credits -> error_o = 1, count still 16.
REQ-047 Reset pulsed with two packets queued -> v_o = 0, out_credits_o = 16, idle_o = 1 on the next cycle.
